// File: rtl/mat_pkg.sv
// Shared types and defaults for the matrix sequencer: FSM states, default dimensions, result byte count.
// No logic, no latency; no flow control of its own.
// Imported by mat_sequencer and mat_tx_serializer.
package mat_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        SEND
    } mat_state_t;

    localparam int MAT_N_DEF  = 3;
    localparam int MAT_W_DEF  = 8;
    localparam int MAT_RW_DEF = 8;

    // Bytes needed to carry one result element of rw bits.
    function automatic int rb_bytes(input int rw);
        return (rw + 7) / 8;
    endfunction

endpackage

// File: rtl/mat_tx_serializer.sv
// Captures the product on i_load and streams it as bytes, element-major, LSB byte first.
// Latency: first byte is valid the cycle after i_load; one byte per accepted handshake.
// Backpressure: o_tx_data and the byte index hold while o_tx_valid is high and i_tx_ready is low.
module mat_tx_serializer
    import mat_pkg::*;
#(
    parameter int N  = MAT_N_DEF,
    parameter int RW = MAT_RW_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [N*N*RW-1:0] i_result,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_last
);

    localparam int RB    = rb_bytes(RW);
    localparam int RBITS = RB * 8;
    localparam int NB    = N * N * RB;
    localparam int KW    = $clog2(NB);

    logic [N*N*RW-1:0] res_q;
    logic [NB*8-1:0]   res_pad;
    logic [KW-1:0]     k;

    // Zero-extend every element to a whole number of bytes so byte k is a plain slice.
    for (genvar e = 0; e < N * N; e++) begin : g_pad
        assign res_pad[e*RBITS +: RBITS] = RBITS'(res_q[e*RW +: RW]);
    end

    assign o_last    = o_tx_valid && i_tx_ready && (k == KW'(NB - 1));
    assign o_tx_data = o_tx_valid ? res_pad[k*8 +: 8] : 8'h00;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_q      <= '0;
            k          <= '0;
            o_tx_valid <= 1'b0;
        end else if (i_load) begin
            res_q      <= i_result;
            k          <= '0;
            o_tx_valid <= 1'b1;
        end else if (o_tx_valid && i_tx_ready) begin
            if (o_last) begin
                k          <= '0;
                o_tx_valid <= 1'b0;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_sequencer.sv
// Loads operands A and B from a byte stream, kicks the multiplier, then serializes the product.
// Latency: o_start one cycle after the last B byte; result bytes start the cycle after i_done.
// Backpressure: rx has none (bytes outside LOAD_A/LOAD_B pulse o_drop); tx is valid/ready. Optional stall timer: MAT_SEQ_TIMEOUT_EN.
module mat_sequencer
    import mat_pkg::*;
#(
    parameter int N       = MAT_N_DEF,
    parameter int W       = MAT_W_DEF,
    parameter int RW      = MAT_RW_DEF,
    parameter int TIMEOUT = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [N*N*W-1:0]  o_mat_a,
    output logic [N*N*W-1:0]  o_mat_b,
    output logic              o_start,
    input  logic              i_done,
    input  logic [N*N*RW-1:0] i_result,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_drop,
    output logic              o_err
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);

    mat_state_t    state;
    logic [IW-1:0] idx;
    logic          last_elem;
    logic          load_res;
    logic          tx_last;
    logic          timeout_hit;

    assign last_elem = (idx == IW'(NN - 1));
    assign load_res  = (state == WAIT) && i_done;
    assign o_busy    = (state != LOAD_A);

`ifdef MAT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr;
    logic          tmr_run;

    // Only a partially received frame can stall; an idle LOAD_A with idx 0 is not a stall.
    assign tmr_run     = ((state == LOAD_A) && (idx != '0)) || (state == LOAD_B);
    assign timeout_hit = tmr_run && !i_rx_valid && (tmr == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmr   <= '0;
            o_err <= 1'b0;
        end else begin
            if (!tmr_run || i_rx_valid || timeout_hit) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end
            if (timeout_hit) begin
                o_err <= 1'b1;
            end else if ((state == LOAD_A) && (idx == '0) && i_rx_valid) begin
                o_err <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign o_err          = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= LOAD_A;
            idx     <= '0;
            o_mat_a <= '0;
            o_mat_b <= '0;
            o_start <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_start <= 1'b0;
            o_drop  <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (timeout_hit) begin
                        idx <= '0;
                    end else if (i_rx_valid) begin
                        o_mat_a[idx*W +: W] <= i_rx_data[W-1:0];
                        if (last_elem) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (timeout_hit) begin
                        idx   <= '0;
                        state <= LOAD_A;
                    end else if (i_rx_valid) begin
                        o_mat_b[idx*W +: W] <= i_rx_data[W-1:0];
                        if (last_elem) begin
                            idx     <= '0;
                            state   <= START;
                            o_start <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                START: begin
                    o_drop <= i_rx_valid;
                    state  <= WAIT;
                end
                WAIT: begin
                    o_drop <= i_rx_valid;
                    if (i_done) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    o_drop <= i_rx_valid;
                    if (tx_last) begin
                        state <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    mat_tx_serializer #(
        .N  (N),
        .RW (RW)
    ) u_tx (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (load_res),
        .i_result   (i_result),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_last     (tx_last)
    );

endmodule

// File: tb/tb_mat_sequencer.sv
// Directed bench for mat_sequencer (N=3, W=8, RW=8, TIMEOUT=100) with a tx byte scoreboard.
// Expected tx bytes are queued when i_done is driven and compared on each accepted handshake.
module tb_mat_sequencer;

    localparam int N       = 3;
    localparam int W       = 8;
    localparam int RW      = 8;
    localparam int TIMEOUT = 100;
    localparam int NN      = N * N;

    logic              i_clk;
    logic              i_rst;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic [NN*W-1:0]   o_mat_a;
    logic [NN*W-1:0]   o_mat_b;
    logic              o_start;
    logic              i_done;
    logic [NN*RW-1:0]  i_result;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic              o_busy;
    logic              o_drop;
    logic              o_err;

    int checks     = 0;
    int errors     = 0;
    int start_cnt  = 0;
    int exp_starts = 0;

    logic [7:0]          sb[$];
    logic [NN-1:0][7:0]  exp_a;
    logic [NN-1:0][7:0]  exp_b;
    logic [NN-1:0][7:0]  res;
    logic [NN-1:0][7:0]  saved_a;
    logic [NN-1:0][7:0]  saved_b;

    mat_sequencer #(
        .N       (N),
        .W       (W),
        .RW      (RW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_mat_a    (o_mat_a),
        .o_mat_b    (o_mat_b),
        .o_start    (o_start),
        .i_done     (i_done),
        .i_result   (i_result),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_drop     (o_drop),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        i_rx_data  = v;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NN; i++) begin
            exp_a[i] = 8'($urandom);
            exp_b[i] = 8'($urandom);
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < NN; i++) send_byte(exp_a[i]);
        chk("busy_in_load_b", o_busy, 1);
        for (int i = 0; i < NN; i++) begin
            send_byte(exp_b[i]);
            if (i == NN - 2) chk("start_not_early", o_start, 0);
        end
        chk("start_pulse", o_start, 1);
        chk("mat_a", o_mat_a, exp_a);
        chk("mat_b", o_mat_b, exp_b);
        exp_starts++;
        tick();
        chk("start_one_cycle", o_start, 0);
        chk("busy_in_wait", o_busy, 1);
    endtask

    // Drives i_done, queues the expected bytes and drains with a repeating 4-cycle ready pattern.
    task automatic run_result(input logic [3:0] pat, input int exp_cycles);
        int cyc;
        i_result = res;
        i_done   = 1'b1;
        for (int i = 0; i < NN; i++) sb.push_back(res[i]);
        tick();
        i_done   = 1'b0;
        i_result = ~res;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            i_tx_ready = pat[cyc % 4];
            tick();
            cyc++;
        end
        i_tx_ready = 1'b0;
        chk("drain_cycles", cyc, exp_cycles);
        chk("tx_valid_after_frame", o_tx_valid, 0);
        chk("busy_after_frame", o_busy, 0);
    endtask

    // tx monitor: scoreboard compare on handshake, data-hold check across stalls.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                prev_stall = 1'b0;
            end else begin
                if (o_start) start_cnt++;
                if (prev_stall) chk("tx_hold_during_stall", {o_tx_valid, o_tx_data}, {1'b1, prev_data});
                if (o_tx_valid && i_tx_ready) begin
                    if (sb.size() == 0) chk("tx_byte_expected", sb.size(), 1);
                    else chk("tx_byte", o_tx_data, sb.pop_front());
                end
                prev_stall = o_tx_valid && !i_tx_ready;
                prev_data  = o_tx_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst      = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_done     = 1'b0;
        i_result   = '0;
        i_tx_ready = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        chk("rst_start", o_start, 0);
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_err", o_err, 0);
        chk("rst_mat_a", o_mat_a, 0);
        chk("rst_mat_b", o_mat_b, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // i_done outside WAIT must be ignored
        for (int i = 0; i < NN; i++) res[i] = 8'($urandom);
        i_result = res;
        i_done   = 1'b1;
        tick();
        i_done = 1'b0;
        chk("done_ignored_busy", o_busy, 0);
        chk("done_ignored_tx", o_tx_valid, 0);

        // Frame 1: A = 1..9, B = 9..1, result 0x10..0x18 with ready held high
        for (int i = 0; i < NN; i++) begin
            exp_a[i] = 8'(i + 1);
            exp_b[i] = 8'(9 - i);
        end
        load_frame();
        chk("a_elem0", o_mat_a[7:0], 8'd1);
        chk("a_elem8", o_mat_a[71:64], 8'd9);
        chk("b_elem0", o_mat_b[7:0], 8'd9);
        for (int i = 0; i < NN; i++) res[i] = 8'(8'h10 + i);
        run_result(4'b1111, 9);

        // Frame 2: byte dropped in WAIT, then ready pattern 1,0,0,1
        rand_frame();
        load_frame();
        saved_a = exp_a;
        saved_b = exp_b;
        send_byte(8'hEE);
        chk("drop_pulse", o_drop, 1);
        chk("drop_keeps_a", o_mat_a, saved_a);
        chk("drop_keeps_b", o_mat_b, saved_b);
        tick();
        chk("drop_one_cycle", o_drop, 0);
        for (int i = 0; i < NN; i++) res[i] = 8'($urandom);
        run_result(4'b1001, 17);

        // Frame 3 follows the dropped byte cleanly
        rand_frame();
        load_frame();
        for (int i = 0; i < NN; i++) res[i] = 8'($urandom);
        run_result(4'b1111, 9);

        // Reset after 5 A bytes abandons the frame
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
        i_rst = 1'b1;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_mat_a", o_mat_a, 0);
        chk("midrst_mat_b", o_mat_b, 0);
        tick();
        tick();
        i_rst = 1'b0;
        rand_frame();
        load_frame();
        for (int i = 0; i < NN; i++) res[i] = 8'($urandom);
        run_result(4'b0110, 18);

`ifdef MAT_SEQ_TIMEOUT_EN
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
        repeat (TIMEOUT - 1) tick();
        chk("err_before_timeout", o_err, 0);
        tick();
        chk("err_at_timeout", o_err, 1);
        chk("busy_at_timeout", o_busy, 0);
        send_byte(8'h5A);
        chk("err_cleared", o_err, 0);
        chk("after_timeout_a_elem0", o_mat_a[7:0], 8'h5A);
        chk("after_timeout_a_elem1", o_mat_a[15:8], 8'h32);
`else
        // Without the timer a partial frame waits indefinitely
        rand_frame();
        for (int i = 0; i < 4; i++) send_byte(exp_a[i]);
        repeat (TIMEOUT + 50) tick();
        chk("stall_err_zero", o_err, 0);
        chk("stall_still_load_a", o_busy, 0);
        for (int i = 4; i < NN; i++) send_byte(exp_a[i]);
        chk("stall_resumed_load_b", o_busy, 1);
        for (int i = 0; i < NN; i++) send_byte(exp_b[i]);
        chk("stall_start", o_start, 1);
        chk("stall_mat_a", o_mat_a, exp_a);
        chk("stall_mat_b", o_mat_b, exp_b);
        exp_starts++;
        tick();
        for (int i = 0; i < NN; i++) res[i] = 8'($urandom);
        run_result(4'b1111, 9);
`endif

        tick();
        chk("start_pulse_count", start_cnt, exp_starts);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_sequencer.md
MAT_SEQUENCER -- requirements
Module: mat_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the square matrix dimension (N >= 2).
REQ-002 The block SHALL have parameter W, default 8, meaning the operand element width; each element arrives as exactly one byte, so W <= 8, zero-extended.
REQ-003 The block SHALL have parameter RW, default 8, meaning the result element width; each element is sent as RB = ceil(RW/8) bytes, LSB first.
REQ-004 The block SHALL have parameter TIMEOUT, default 1000000, meaning the inter-byte stall limit in clock cycles.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Port i_clk, input, 1 bit: system clock.
REQ-007 Port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port i_rx_data, input, 8 bits: received byte.
REQ-009 Port i_rx_valid, input, 1 bit: one-cycle strobe qualifying i_rx_data.
REQ-010 Port o_mat_a, output, N*N*W bits: flattened operand A, row-major, element 0 in the LSBs.
REQ-011 Port o_mat_b, output, N*N*W bits: flattened operand B, same packing as A.
REQ-012 Port o_start, output, 1 bit: one-cycle pulse telling the multiplier to begin.
REQ-013 Port i_done, input, 1 bit: one-cycle pulse meaning i_result is valid.
REQ-014 Port i_result, input, N*N*RW bits: flattened product, row-major.
REQ-015 Port o_tx_data, output, 8 bits: byte to transmit.
REQ-016 Port o_tx_valid, output, 1 bit: o_tx_data is valid.
REQ-017 Port i_tx_ready, input, 1 bit: transmitter accepts the byte this cycle.
REQ-018 Port o_busy, output, 1 bit: high in every state except LOAD_A.
REQ-019 Port o_drop, output, 1 bit: one-cycle pulse when an rx byte is discarded.
REQ-020 Port o_err, output, 1 bit: sticky timeout flag.

Function
REQ-021 The FSM SHALL have states LOAD_A, LOAD_B, START, WAIT and SEND, with a single element/byte index counter.
REQ-022 In LOAD_A and LOAD_B, each i_rx_valid byte SHALL be written to element[idx] of the current bank and idx SHALL be incremented.
REQ-023 On the N*N-th byte, idx SHALL clear and the FSM SHALL advance (LOAD_A->LOAD_B, LOAD_B->START).
REQ-024 In START, o_start SHALL be high for exactly one cycle (the cycle after the last B byte), and the FSM SHALL then go to WAIT.
REQ-025 In WAIT, i_done SHALL capture i_result into an internal result register and move the FSM to SEND; i_done in any other state SHALL be ignored.
REQ-026 In SEND, o_tx_valid SHALL be held high with byte k of the serialized result, and k SHALL advance only on o_tx_valid && i_tx_ready.
REQ-027 o_tx_data SHALL remain stable while o_tx_valid is high and i_tx_ready is low.
REQ-028 After N*N*RB bytes are accepted, o_tx_valid SHALL drop in the same cycle and the FSM SHALL return to LOAD_A.
REQ-029 An i_rx_valid in START, WAIT or SEND SHALL discard the byte and pulse o_drop for one cycle.
REQ-030 o_mat_a and o_mat_b SHALL hold their values from START until the next write to the same bank.
REQ-031 Result bytes SHALL be taken from the registered capture, never live from i_result.

Reset
REQ-032 Asserting i_rst SHALL immediately set state LOAD_A, clear idx and k, and zero both banks and the result register.
REQ-033 While i_rst is asserted, o_start, o_tx_valid, o_tx_data, o_busy, o_drop and o_err SHALL all be 0.
REQ-034 A reset mid-frame SHALL abandon the frame; the next byte after release SHALL be A element 0.

Configuration
REQ-035 With macro MAT_SEQ_TIMEOUT_EN defined, a counter SHALL run in LOAD_A (idx > 0) and in LOAD_B, and SHALL be cleared by every received byte.
REQ-036 With MAT_SEQ_TIMEOUT_EN defined, reaching TIMEOUT SHALL return the FSM to LOAD_A with idx 0 and set o_err.
REQ-037 With MAT_SEQ_TIMEOUT_EN defined, o_err SHALL clear on the first byte of the next frame or on reset.
REQ-038 Without MAT_SEQ_TIMEOUT_EN, no timer SHALL exist, a partial frame SHALL wait indefinitely, and o_err SHALL be tied 0.

Structure
REQ-039 Package mat_pkg SHALL hold the state enum, the default N/W/RW values and an RB helper function.
REQ-040 The byte serialization and ready/valid stage SHALL be sub-module mat_tx_serializer.

Verification
REQ-041 N=3: bytes 1..9 then 9..1 -> o_mat_a element0=1, element8=9; o_mat_b element0=9; one o_start pulse one cycle after the 18th byte.
REQ-042 i_done with i_result elements 0x10..0x18, i_tx_ready=1 -> 9 bytes 0x10..0x18 on consecutive cycles, then LOAD_A with o_busy=0.
REQ-043 i_tx_ready toggling 1,0,0,1 -> o_tx_data constant through stalls, no byte lost or duplicated.
REQ-044 Byte sent during WAIT -> o_drop one-cycle pulse, banks unchanged, and the following frame loads correctly.
REQ-045 Reset after 5 A bytes, then a full 18-byte frame -> correct operands, no residue from the aborted frame.
REQ-046 MAT_SEQ_TIMEOUT_EN with TIMEOUT=100: 4 bytes, then 100 idle cycles -> o_err=1, idx=0; the next byte clears o_err and is stored as A element 0.
